// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state, transaction owner and
// default widths. Package name riscv_pkg is shared with the rest of the core.
package riscv_pkg;

   localparam int unsigned DEF_ADDR_W       = 32;
   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_STARVE_LIMIT = 4;
   localparam int unsigned DEF_TIMEOUT_CYC  = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_GNT  = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by fetch and data access, data has priority
// with a starvation limit for fetch. Optional response timeout: MEM_TIMEOUT_EN.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                err_o
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   if (STARVE_LIMIT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("mem_port_arbiter: STARVE_LIMIT and TIMEOUT_CYC must be at least 1");
   end

   arb_state_t          state_q;
   owner_t              owner_q;
   logic [SC_W-1:0]     starve_q;
   logic [SC_W-1:0]     starve_d;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [BE_W-1:0]     mem_be_q;
   logic                pick_data_s;
   logic                timeout_s;

   // Arbitration: data wins unless fetch has lost STARVE_LIMIT times in a row.
   always_comb begin
      pick_data_s = d_req && !(if_req && (starve_q == SC_W'(STARVE_LIMIT)));
      // pick_data_s is false once the limit is hit, so the count never exceeds it
      if (pick_data_s && if_req) begin
         starve_d = starve_q + SC_W'(1);
      end else begin
         starve_d = {SC_W{1'b0}};
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tcnt_q;

   // Response wait counter, zero on every entry into WAIT_RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= {TO_W{1'b0}};
      end else if (state_q == WAIT_RESP) begin
         tcnt_q <= tcnt_q + TO_W'(1);
      end else begin
         tcnt_q <= {TO_W{1'b0}};
      end
   end

   assign timeout_s = (state_q == WAIT_RESP) && (tcnt_q == TO_W'(TIMEOUT_CYC));
`else
   assign timeout_s = 1'b0;
`endif

   // Transaction FSM with registered memory-side request attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         starve_q    <= {SC_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         mem_be_q    <= {BE_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (if_req || d_req) begin
                  state_q   <= WAIT_GNT;
                  mem_req_q <= 1'b1;
                  starve_q  <= starve_d;
                  if (pick_data_s) begin
                     owner_q     <= OWN_D;
                     mem_we_q    <= d_we;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_be_q    <= d_be;
                  end else begin
                     owner_q     <= OWN_IF;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr;
                     mem_wdata_q <= {DATA_W{1'b0}};
                     mem_be_q    <= {BE_W{1'b1}};
                  end
               end
            end
            WAIT_GNT: begin
               if (mem_gnt) begin
                  state_q   <= WAIT_RESP;
                  mem_req_q <= 1'b0;
               end
            end
            WAIT_RESP: begin
               if (mem_rvalid || timeout_s) begin
                  state_q <= IDLE;
                  owner_q <= OWN_NONE;
               end
            end
            default: begin
               state_q   <= IDLE;
               owner_q   <= OWN_NONE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Grant and response routing to the current owner; nothing leaks during reset.
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = {DATA_W{1'b0}};
      d_rdata   = {DATA_W{1'b0}};
      err_o     = 1'b0;
      if (!rst) begin
         case (state_q)
            WAIT_GNT: begin
               if_gnt = mem_gnt && (owner_q == OWN_IF);
               d_gnt  = mem_gnt && (owner_q == OWN_D);
            end
            WAIT_RESP: begin
               if_rvalid = (mem_rvalid || timeout_s) && (owner_q == OWN_IF);
               d_rvalid  = (mem_rvalid || timeout_s) && (owner_q == OWN_D);
               err_o     = timeout_s && !mem_rvalid;
               if (timeout_s && !mem_rvalid) begin
                  if_rdata = {DATA_W{1'b0}};
                  d_rdata  = {DATA_W{1'b0}};
               end else begin
                  if_rdata = mem_rdata;
                  d_rdata  = mem_rdata;
               end
            end
            default: begin
               if_gnt = 1'b0;
            end
         endcase
      end else begin
         err_o = 1'b0;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int SL = 4;
   localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [BW-1:0] d_be;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic          mem_gnt, mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          busy, err_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = no transaction, 1 = address offered, 2 = awaiting data.
   int            m_phase = 0;
   int            m_who   = 0;
   int            m_starve = 0;
   int            m_tcnt  = 0;
   logic [AW-1:0] m_addr  = '0;
   logic          m_we    = 1'b0;
   logic [DW-1:0] m_wdata = '0;
   logic [BW-1:0] m_be    = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase  <= 0;
         m_who    <= 0;
         m_starve <= 0;
         m_tcnt   <= 0;
      end else if (m_phase == 0) begin
         if (if_req || d_req) begin
            m_phase <= 1;
            if (d_req && !(if_req && m_starve == SL)) begin
               m_who    <= 2;
               m_addr   <= d_addr;
               m_we     <= d_we;
               m_wdata  <= d_wdata;
               m_be     <= d_be;
               m_starve <= if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
            end else begin
               m_who    <= 1;
               m_addr   <= if_addr;
               m_we     <= 1'b0;
               m_starve <= 0;
            end
         end
      end else if (m_phase == 1) begin
         if (mem_gnt) begin
            m_phase <= 2;
            m_tcnt  <= 0;
         end
      end else begin
         if (mem_rvalid || (TO_ON && m_tcnt == TO)) begin
            m_phase <= 0;
            m_who   <= 0;
         end else begin
            m_tcnt <= m_tcnt + 1;
         end
      end
   end

   int gnt_log[$];

   always @(negedge clk) begin
      if (if_gnt) gnt_log.push_back(1);
      if (d_gnt)  gnt_log.push_back(2);
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      automatic bit e_to = TO_ON && (m_phase == 2) && (m_tcnt == TO);
      automatic bit e_rv = !rst && (m_phase == 2) && (mem_rvalid || e_to);
      chk("m_busy",     busy,     m_phase != 0);
      chk("m_mem_req",  mem_req,  m_phase == 1);
      chk("m_if_gnt",   if_gnt,   !rst && m_phase == 1 && mem_gnt && m_who == 1);
      chk("m_d_gnt",    d_gnt,    !rst && m_phase == 1 && mem_gnt && m_who == 2);
      chk("m_if_rvalid", if_rvalid, e_rv && m_who == 1);
      chk("m_d_rvalid", d_rvalid, e_rv && m_who == 2);
      chk("m_err",      err_o,    !rst && e_to && !mem_rvalid);
      chk("m_gnt_excl", if_gnt & d_gnt, 1'b0);
      if (m_phase == 1) begin
         chk("m_mem_addr", mem_addr, m_addr);
         chk("m_mem_we",   mem_we,   m_we);
         if (m_who == 2) begin
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_mem_be",    mem_be,    m_be);
         end
      end
      if (e_rv) begin
         chk("m_rdata", (m_who == 1) ? if_rdata : d_rdata,
             mem_rvalid ? mem_rdata : '0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      cyc(); cyc();
      settle();
      chk("rst_busy",    busy,     1'b0);
      chk("rst_mem_req", mem_req,  1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be",  mem_be,   4'h0);
      chk("rst_err",     err_o,    1'b0);

      // Single fetch with immediate grant
      cyc(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
      settle();
      chk("f_c0_mem_req", mem_req, 1'b0);
      cyc(); settle();
      chk("f_c1_mem_req", mem_req, 1'b1);
      chk("f_c1_if_gnt",  if_gnt,  1'b1);
      chk("f_c1_addr",    mem_addr, 32'h100);
      cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      settle();
      chk("f_c2_if_rvalid", if_rvalid, 1'b1);
      chk("f_c2_if_rdata",  if_rdata,  32'hDEADBEEF);
      chk("f_c2_d_rvalid",  d_rvalid,  1'b0);
      cyc(); mem_rvalid = 1'b0; settle();
      chk("f_c3_busy", busy, 1'b0);

      // Both requesters held: starvation limit forces fetch every fifth grant
      cyc();
      if_req = 1'b1; if_addr = 32'h140;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A50000;
      gnt_log.delete();
      repeat (30) cyc();
      if_req = 1'b0; d_req = 1'b0;
      repeat (3) cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("st_count", (gnt_log.size() >= 10), 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("st_order_%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 0, exp_order[i]);
      end

      // Store with a three-cycle grant delay
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234; d_be = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         cyc(); settle();
         chk("s_mem_req",   mem_req,   1'b1);
         chk("s_mem_we",    mem_we,    1'b1);
         chk("s_mem_be",    mem_be,    4'b0011);
         chk("s_mem_wdata", mem_wdata, 32'h1234);
         chk("s_d_gnt_lo",  d_gnt,     1'b0);
      end
      cyc(); mem_gnt = 1'b1; settle();
      chk("s_d_gnt", d_gnt, 1'b1);
      cyc(); d_req = 1'b0; d_we = 1'b0; mem_gnt = 1'b0; settle();
      chk("s_wait_rv", d_rvalid, 1'b0);
      chk("s_wait_busy", busy, 1'b1);
      cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0; settle();
      chk("s_ack",     d_rvalid,  1'b1);
      chk("s_ack_if",  if_rvalid, 1'b0);
      cyc(); mem_rvalid = 1'b0; settle();
      chk("s_done_busy", busy, 1'b0);

      // Spurious events in IDLE and WAIT_GNT, then reset in WAIT_RESP
      cyc(); mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF; settle();
      chk("sp_idle_irv", if_rvalid, 1'b0);
      chk("sp_idle_drv", d_rvalid,  1'b0);
      chk("sp_idle_gnt", if_gnt | d_gnt, 1'b0);
      cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b0; d_req = 1'b1; d_addr = 32'h400; d_be = 4'hF;
      cyc(); mem_rvalid = 1'b1; settle();
      chk("sp_wg_drv", d_rvalid, 1'b0);
      chk("sp_wg_gnt", d_gnt,    1'b0);
      cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
      chk("sp_gnt", d_gnt, 1'b1);
      cyc(); d_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1; settle();
      chk("rr_drv_in_rst", d_rvalid, 1'b0);
      cyc(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555; settle();
      chk("rr_busy",     busy,      1'b0);
      chk("rr_drv",      d_rvalid,  1'b0);
      chk("rr_irv",      if_rvalid, 1'b0);
      chk("rr_mem_req",  mem_req,   1'b0);
      chk("rr_mem_we",   mem_we,    1'b0);
      chk("rr_mem_addr", mem_addr,  32'h0);
      chk("rr_err",      err_o,     1'b0);
      cyc(); mem_rvalid = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // Timeout with no response, then a response landing on the timeout cycle
      cyc(); if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
      cyc(); settle();
      chk("to_gnt", if_gnt, 1'b1);
      cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h77;
      for (int k = 0; k < 8; k++) begin
         settle();
         chk("to_wait_rv",  if_rvalid, 1'b0);
         chk("to_wait_err", err_o,     1'b0);
         cyc();
      end
      settle();
      chk("to_rv",    if_rvalid, 1'b1);
      chk("to_err",   err_o,     1'b1);
      chk("to_rdata", if_rdata,  32'h0);
      cyc(); settle();
      chk("to_idle", busy, 1'b0);
      cyc(); if_req = 1'b1; mem_gnt = 1'b1;
      cyc();
      cyc(); if_req = 1'b0; mem_gnt = 1'b0;
      repeat (8) cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE; settle();
      chk("tr_rv",    if_rvalid, 1'b1);
      chk("tr_rdata", if_rdata,  32'hCAFE);
      chk("tr_err",   err_o,     1'b0);
      cyc(); mem_rvalid = 1'b0; settle();
      chk("tr_idle", busy, 1'b0);
`endif

      repeat (2) cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
